// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte type, S-box size and the PRGA state encoding.
// The key-scheduling block imports the same package.
package rc4_pkg;

    localparam int S_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_LEN = 4'd1,
        WR_LEN = 4'd2,
        RD_SI  = 4'd3,
        RD_SJ  = 4'd4,
        WR_SI  = 4'd5,
        WR_SJ  = 4'd6,
        RD_PAD = 4'd7,
        WR_PT  = 4'd8,
        DONE   = 4'd9
    } state_t;

    // Index arithmetic wraps mod S_SIZE; the 8-bit result drops the carry.
    function automatic byte_t add8(input byte_t a, input byte_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/prga.sv
// RC4 keystream generator and decryptor for a length-prefixed ciphertext.
// It drives S-box, ciphertext and plaintext memories with registered ports.
module prga
    import rc4_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t     state_r,  state_nxt_s;
    logic [1:0] cnt_r,    cnt_nxt_s;
    byte_t      i_r,      i_nxt_s;
    byte_t      j_r,      j_nxt_s;
    byte_t      k_r,      k_nxt_s;
    byte_t      len_r,    len_nxt_s;
    byte_t      si_r,     si_nxt_s;
    byte_t      sj_r,     sj_nxt_s;
    byte_t      ct_r,     ct_nxt_s;
    logic       rdy_r,    rdy_nxt_s;
    byte_t      s_addr_r, s_addr_nxt_s;
    byte_t      s_wd_r,   s_wd_nxt_s;
    logic       s_we_r,   s_we_nxt_s;
    byte_t      ct_addr_r, ct_addr_nxt_s;
    byte_t      pt_addr_r, pt_addr_nxt_s;
    byte_t      pt_wd_r,  pt_wd_nxt_s;
    logic       pt_we_r,  pt_we_nxt_s;
    logic       rd_done_s;

    // A read state ends on the edge that captures data, RD_LAT cycles after the address cycle.
    assign rd_done_s = (cnt_r == LAT);

    // Next-state and next-output logic; addresses are launched on the edge entering each state.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = 2'd0;
        i_nxt_s       = i_r;
        j_nxt_s       = j_r;
        k_nxt_s       = k_r;
        len_nxt_s     = len_r;
        si_nxt_s      = si_r;
        sj_nxt_s      = sj_r;
        ct_nxt_s      = ct_r;
        rdy_nxt_s     = rdy_r;
        s_addr_nxt_s  = s_addr_r;
        s_wd_nxt_s    = s_wd_r;
        s_we_nxt_s    = 1'b0;
        ct_addr_nxt_s = ct_addr_r;
        pt_addr_nxt_s = pt_addr_r;
        pt_wd_nxt_s   = pt_wd_r;
        pt_we_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (en && rdy_r) begin
                    state_nxt_s   = RD_LEN;
                    rdy_nxt_s     = 1'b0;
                    i_nxt_s       = 8'd0;
                    j_nxt_s       = 8'd0;
                    k_nxt_s       = 8'd0;
                    ct_addr_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_LEN: begin
                if (rd_done_s) begin
                    state_nxt_s   = WR_LEN;
                    len_nxt_s     = ct_rddata;
                    pt_addr_nxt_s = 8'd0;
                    pt_wd_nxt_s   = ct_rddata;
                    pt_we_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            // pt[0] and every pt[k] write share the "more bytes?" decision.
            WR_LEN, WR_PT: begin
                if (k_r == len_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s   = RD_SI;
                    i_nxt_s       = add8(i_r, 8'd1);
                    k_nxt_s       = add8(k_r, 8'd1);
                    s_addr_nxt_s  = add8(i_r, 8'd1);
                    ct_addr_nxt_s = add8(k_r, 8'd1);
                end
            end
            RD_SI: begin
                if (rd_done_s) begin
                    state_nxt_s  = RD_SJ;
                    si_nxt_s     = s_rddata;
                    ct_nxt_s     = ct_rddata;
                    j_nxt_s      = add8(j_r, s_rddata);
                    s_addr_nxt_s = add8(j_r, s_rddata);
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            RD_SJ: begin
                if (rd_done_s) begin
                    state_nxt_s  = WR_SI;
                    sj_nxt_s     = s_rddata;
                    s_addr_nxt_s = i_r;
                    s_wd_nxt_s   = s_rddata;
                    s_we_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            WR_SI: begin
                state_nxt_s  = WR_SJ;
                s_addr_nxt_s = j_r;
                s_wd_nxt_s   = si_r;
                s_we_nxt_s   = 1'b1;
            end
            // Swapped pair sums to the same index, so the pad read sees post-swap S.
            WR_SJ: begin
                state_nxt_s  = RD_PAD;
                s_addr_nxt_s = add8(si_r, sj_r);
            end
            RD_PAD: begin
                if (rd_done_s) begin
                    state_nxt_s   = WR_PT;
                    pt_addr_nxt_s = k_r;
                    pt_wd_nxt_s   = s_rddata ^ ct_r;
                    pt_we_nxt_s   = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                rdy_nxt_s   = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
                rdy_nxt_s   = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            i_r       <= 8'd0;
            j_r       <= 8'd0;
            k_r       <= 8'd0;
            len_r     <= 8'd0;
            si_r      <= 8'd0;
            sj_r      <= 8'd0;
            ct_r      <= 8'd0;
            rdy_r     <= 1'b1;
            s_addr_r  <= 8'd0;
            s_wd_r    <= 8'd0;
            s_we_r    <= 1'b0;
            ct_addr_r <= 8'd0;
            pt_addr_r <= 8'd0;
            pt_wd_r   <= 8'd0;
            pt_we_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            i_r       <= i_nxt_s;
            j_r       <= j_nxt_s;
            k_r       <= k_nxt_s;
            len_r     <= len_nxt_s;
            si_r      <= si_nxt_s;
            sj_r      <= sj_nxt_s;
            ct_r      <= ct_nxt_s;
            rdy_r     <= rdy_nxt_s;
            s_addr_r  <= s_addr_nxt_s;
            s_wd_r    <= s_wd_nxt_s;
            s_we_r    <= s_we_nxt_s;
            ct_addr_r <= ct_addr_nxt_s;
            pt_addr_r <= pt_addr_nxt_s;
            pt_wd_r   <= pt_wd_nxt_s;
            pt_we_r   <= pt_we_nxt_s;
        end
    end

    assign rdy       = rdy_r;
    assign s_addr    = s_addr_r;
    assign s_wrdata  = s_wd_r;
    assign s_wren    = s_we_r;
    assign ct_addr   = ct_addr_r;
    assign pt_addr   = pt_addr_r;
    assign pt_wrdata = pt_wd_r;
    assign pt_wren   = pt_we_r;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: two instances (RD_LAT 1 and 3) on latency-modelled memories,
// checked against a plain RC4 PRGA reference computed inside the bench.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst;
    logic       en        [2];
    logic       rdy       [2];
    logic [7:0] s_addr    [2];
    logic [7:0] s_rddata  [2];
    logic [7:0] s_wrdata  [2];
    logic       s_wren    [2];
    logic [7:0] ct_addr   [2];
    logic [7:0] ct_rddata [2];
    logic [7:0] pt_addr   [2];
    logic [7:0] pt_wrdata [2];
    logic       pt_wren   [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prga #(.RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]),
        .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
        .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
        .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
    );

    prga #(.RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]),
        .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
        .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
        .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
    );

    // Memories: reads return data RD_LAT edges after the address is seen.
    logic [7:0] smem  [2][256];
    logic [7:0] ctmem [2][256];
    logic [7:0] ptmem [2][256];
    logic [7:0] sp    [2][3];
    logic [7:0] cp    [2][3];
    int s_wr_cnt [2] = '{0, 0};
    int pt_wr_cnt[2] = '{0, 0};
    int pt_cyc   [2][256];
    int both_cnt = 0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int g = 0; g < 2; g++) begin
            sp[g][2] <= sp[g][1];
            sp[g][1] <= sp[g][0];
            sp[g][0] <= smem[g][s_addr[g]];
            cp[g][2] <= cp[g][1];
            cp[g][1] <= cp[g][0];
            cp[g][0] <= ctmem[g][ct_addr[g]];
            if (s_wren[g] === 1'b1) begin
                smem[g][s_addr[g]] = s_wrdata[g];
                s_wr_cnt[g] = s_wr_cnt[g] + 1;
            end
            if (pt_wren[g] === 1'b1) begin
                ptmem[g][pt_addr[g]] = pt_wrdata[g];
                pt_cyc[g][pt_addr[g]] = cyc;
                pt_wr_cnt[g] = pt_wr_cnt[g] + 1;
            end
            if (s_wren[g] === 1'b1 && pt_wren[g] === 1'b1) both_cnt = both_cnt + 1;
        end
    end

    assign s_rddata[0]  = sp[0][0];
    assign s_rddata[1]  = sp[1][2];
    assign ct_rddata[0] = cp[0][0];
    assign ct_rddata[1] = cp[1][2];

    int ms  [256];
    int mct [256];

    task automatic load(input int g, input int len, input bit ident, input bit zero_ct);
        int r, t;
        for (int x = 0; x < 256; x++) ms[x] = x;
        if (!ident) begin
            for (int x = 255; x > 0; x--) begin
                r = $urandom_range(0, x);
                t = ms[x]; ms[x] = ms[r]; ms[r] = t;
            end
        end
        mct[0] = len;
        for (int x = 1; x < 256; x++) mct[x] = zero_ct ? 0 : $urandom_range(0, 255);
        for (int x = 0; x < 256; x++) begin
            smem[g][x]  = 8'(ms[x]);
            ctmem[g][x] = 8'(mct[x]);
            ptmem[g][x] = 8'h00;
        end
    endtask

    // Runs one message on instance g and compares pt, S, write counts and per-byte timing.
    task automatic run_check(input int g, input bit busy_pulse, input string tag);
        int len, n, s0, p0, ii, jj, t, bad, exp_pb, budget;
        int es[256];
        int ep[256];
        len = mct[0];
        es = ms;
        ii = 0; jj = 0; ep[0] = len;
        for (int k = 1; k <= len; k++) begin
            ii = (ii + 1) % 256;
            jj = (jj + es[ii]) % 256;
            t = es[ii]; es[ii] = es[jj]; es[jj] = t;
            ep[k] = es[(es[ii] + es[jj]) % 256] ^ mct[k];
        end
        exp_pb = (g == 0) ? 9 : 15;
        budget = 20 * (len + 2) + 20;
        s0 = s_wr_cnt[g];
        p0 = pt_wr_cnt[g];
        @(negedge clk); en[g] = 1'b1;
        @(negedge clk); en[g] = 1'b0;
        checks++;
        if (rdy[g] !== 1'b0) begin
            failures++;
            $display("FAIL %s[%0d] start_rdy got %b exp 0", tag, g, rdy[g]);
        end
        n = 0;
        while (rdy[g] !== 1'b1 && n < budget) begin
            @(negedge clk);
            if (busy_pulse) en[g] = 1'($urandom_range(0, 1));
            n++;
        end
        en[g] = 1'b0;
        checks++;
        if (rdy[g] !== 1'b1) begin
            failures++;
            $display("FAIL %s[%0d] timeout rdy got %b exp 1 after %0d cycles", tag, g, rdy[g], n);
        end
        for (int k = 0; k <= len; k++) begin
            checks++;
            if (ptmem[g][k] !== 8'(ep[k])) begin
                failures++;
                $display("FAIL %s[%0d] pt[%0d] got %02h exp %02h", tag, g, k, ptmem[g][k], 8'(ep[k]));
            end
        end
        for (int k = 1; k <= len; k++) begin
            checks++;
            if (pt_cyc[g][k] - pt_cyc[g][k-1] !== exp_pb) begin
                failures++;
                $display("FAIL %s[%0d] byte_cycles k=%0d got %0d exp %0d", tag, g, k,
                         pt_cyc[g][k] - pt_cyc[g][k-1], exp_pb);
            end
        end
        bad = 0;
        for (int x = 0; x < 256; x++) if (smem[g][x] !== 8'(es[x])) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s[%0d] sbox got %0d differing entries exp 0", tag, g, bad);
        end
        checks++;
        if (pt_wr_cnt[g] - p0 !== len + 1) begin
            failures++;
            $display("FAIL %s[%0d] pt_writes got %0d exp %0d", tag, g, pt_wr_cnt[g] - p0, len + 1);
        end
        checks++;
        if (s_wr_cnt[g] - s0 !== 2 * len) begin
            failures++;
            $display("FAIL %s[%0d] s_writes got %0d exp %0d", tag, g, s_wr_cnt[g] - s0, 2 * len);
        end
        ms = es;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({rdy[g], s_wren[g], pt_wren[g]} !== 3'b100) begin
                failures++;
                $display("FAIL reset[%0d] rdy/s_wren/pt_wren got %b%b%b exp 100", g, rdy[g], s_wren[g], pt_wren[g]);
            end
            checks++;
            if ({s_addr[g], ct_addr[g], pt_addr[g]} !== 24'h000000) begin
                failures++;
                $display("FAIL reset[%0d] addrs got %02h %02h %02h exp 00 00 00", g, s_addr[g], ct_addr[g], pt_addr[g]);
            end
            checks++;
            if ({s_wrdata[g], pt_wrdata[g]} !== 16'h0000) begin
                failures++;
                $display("FAIL reset[%0d] wrdata got %02h %02h exp 00 00", g, s_wrdata[g], pt_wrdata[g]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_len_zero(input int g);
        load(g, 0, 1'b0, 1'b0);
        run_check(g, 1'b0, "len_zero");
    endtask

    task automatic test_identity_one(input int g);
        load(g, 1, 1'b1, 1'b1);
        run_check(g, 1'b0, "ident1");
        checks++;
        if (ptmem[g][1] !== 8'h02) begin
            failures++;
            $display("FAIL ident1[%0d] pt[1] got %02h exp 02", g, ptmem[g][1]);
        end
    endtask

    task automatic test_identity_two(input int g, input bit busy, input string tag);
        load(g, 2, 1'b1, 1'b1);
        run_check(g, busy, tag);
        checks++;
        if ({ptmem[g][1], ptmem[g][2]} !== 16'h0205) begin
            failures++;
            $display("FAIL %s[%0d] pt[1..2] got %02h %02h exp 02 05", tag, g, ptmem[g][1], ptmem[g][2]);
        end
        checks++;
        if ({smem[g][2], smem[g][3]} !== 16'h0302) begin
            failures++;
            $display("FAIL %s[%0d] s[2..3] got %02h %02h exp 03 02", tag, g, smem[g][2], smem[g][3]);
        end
    endtask

    task automatic test_random(input int g, input int iters);
        for (int it = 0; it < iters; it++) begin
            load(g, $urandom_range(1, 40), 1'b0, 1'b0);
            run_check(g, 1'b0, "random");
        end
        load(g, 255, 1'b0, 1'b0);
        run_check(g, 1'b0, "len_max");
    endtask

    task automatic test_rst_mid(input int g);
        int n, s0, p0;
        load(g, 5, 1'b0, 1'b0);
        @(negedge clk); en[g] = 1'b1;
        @(negedge clk); en[g] = 1'b0;
        n = 0;
        while (s_wren[g] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_wren[g] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid[%0d] reach_wr_si got %b exp 1", g, s_wren[g]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rdy[g], s_wren[g], pt_wren[g]} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid[%0d] rdy/s_wren/pt_wren got %b%b%b exp 100", g, rdy[g], s_wren[g], pt_wren[g]);
        end
        s0 = s_wr_cnt[g];
        p0 = pt_wr_cnt[g];
        repeat (60) @(negedge clk);
        checks++;
        if ((s_wr_cnt[g] - s0) + (pt_wr_cnt[g] - p0) !== 0) begin
            failures++;
            $display("FAIL rst_mid[%0d] writes_after_rst got %0d exp 0", g,
                     (s_wr_cnt[g] - s0) + (pt_wr_cnt[g] - p0));
        end
        checks++;
        if (rdy[g] !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid[%0d] idle_rdy got %b exp 1", g, rdy[g]);
        end
    endtask

    task automatic test_write_exclusive();
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL write_exclusive both_wren_cycles got %0d exp 0", both_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        en[0] = 1'b0;
        en[1] = 1'b0;
        test_reset();
        for (int g = 0; g < 2; g++) begin
            test_len_zero(g);
            test_identity_one(g);
            test_identity_two(g, 1'b0, "ident2");
            test_identity_two(g, 1'b1, "busy_en");
            test_random(g, 6);
            test_rst_mid(g);
        end
        test_write_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 Parameter RD_LAT, default 1, synchronous memory read latency in cycles; legal range 1..3.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  start request; sampled only while rdy=1.
REQ-005 rdy  output  1  high = idle and able to accept en.
REQ-006 s_addr  output  8  S-box memory address.
REQ-007 s_rddata  input  8  S-box read data, valid RD_LAT cycles after s_addr is registered.
REQ-008 s_wrdata  output  8  S-box write data.
REQ-009 s_wren  output  1  S-box write enable, one cycle per write.
REQ-010 ct_addr  output  8  ciphertext memory address (read-only memory).
REQ-011 ct_rddata  input  8  ciphertext read data, same latency as s_rddata.
REQ-012 pt_addr  output  8  plaintext memory address.
REQ-013 pt_wrdata  output  8  plaintext write data.
REQ-014 pt_wren  output  1  plaintext write enable, one cycle per write.

Function
REQ-015 The block SHALL run RC4 keystream generation over an S-box already scheduled by the key-scheduling block, and decrypt a length-prefixed message: ct[0]=L (0..255), ct[1..L]=data.
REQ-016 Start: en=1 while rdy=1 SHALL drop rdy on the next edge; en while rdy=0 SHALL be ignored.
REQ-017 The block SHALL clear i=0 and j=0, read L=ct[0], and write pt[0]=L.
REQ-018 For k=1..L: i=(i+1) mod 256; j=(j+s[i]) mod 256; swap s[i] and s[j]; pad=s[(s[i]+s[j]) mod 256]; pt[k]=pad XOR ct[k].
REQ-019 All index sums SHALL be 8-bit and wrap mod 256 with no carry retained.
REQ-020 FSM states: IDLE, RD_LEN, WR_LEN, RD_SI (ct[k] read in parallel), RD_SJ, WR_SI, WR_SJ, RD_PAD, WR_PT, DONE.
REQ-021 Each RD_* state SHALL last 1+RD_LAT cycles: address drive, then RD_LAT wait cycles, with data captured on the last edge.
REQ-022 WR_SI SHALL write s[i]=old s[j]; WR_SJ SHALL write s[j]=old s[i]; each lasts exactly one cycle with s_wren=1.
REQ-023 RD_PAD SHALL be issued only after WR_SJ completes, so the pad sees the post-swap S-box.
REQ-024 Per-byte cost SHALL be exactly 3*(1+RD_LAT)+3 cycles (9 at RD_LAT=1).
REQ-025 i==j SHALL be handled naturally: both swap writes store the same value and S is unchanged.
REQ-026 L=0 SHALL write only pt[0]=0, then go to DONE with no S-box accesses.
REQ-027 After WR_PT with k==L, the FSM SHALL enter DONE and then IDLE; rdy SHALL rise on entry to IDLE.
REQ-028 At most one of s_wren/pt_wren SHALL be high in any cycle; all write enables SHALL be 0 in IDLE, DONE and every RD_* state.

Reset
REQ-029 rst=1 SHALL force IDLE, rdy=1, i=j=k=L=0, and all addr/wrdata/wren outputs to 0 on the next edge.
REQ-030 rst asserted mid-operation SHALL abort with no further writes; partially swapped S and pt contents are undefined.
REQ-031 rst SHALL take priority over en in the same cycle.

Structure
REQ-032 Package rc4_pkg SHALL hold the FSM state enum, the S_SIZE=256 constant and the byte type, shared with the key-scheduling block.
REQ-033 The block SHALL have no sub-modules; the FSM, the index registers and the RD_LAT wait counter SHALL live in prga.

Verification
REQ-034 Reset: hold rst 2 cycles -> rdy=1, s_wren=pt_wren=0, all addresses 0.
REQ-035 L=0, ct[0]=0x00, pulse en -> exactly one pt write (pt[0]=0x00), zero s_wren pulses, rdy returns to 1.
REQ-036 Identity S (s[x]=x), ct={0x01,0x00} -> i=j=1, pt[1]=0x02, S unchanged.
REQ-037 Identity S, ct={0x02,0x00,0x00} -> pt[1]=0x02, pt[2]=0x05, then s[2]=0x03, s[3]=0x02; per-byte cycle count is 9 at RD_LAT=1 and 15 at RD_LAT=3.
REQ-038 en re-pulsed while busy -> ignored, results identical to REQ-037; rst asserted during WR_SI -> next cycle rdy=1, no further writes.
